// File: rtl/hazard_scoreboard_unit.sv
// hazard_scoreboard_unit: ID-stage stall controller with per-register countdown scoreboard
module hazard_scoreboard_unit #(
  parameter int REGW     = 5,
  parameter int LOAD_LAT = 1,
  parameter int MD_LAT   = 3,
  parameter int BR_EXTRA = 1,
  parameter int MD_OCC   = 4,
  parameter int CNTW     = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  input  logic [REGW-1:0] id_rs,
  input  logic [REGW-1:0] id_rt,
  input  logic            id_uses_rs,
  input  logic            id_uses_rt,
  input  logic            id_is_branch,
  input  logic            id_regwrite,
  input  logic [REGW-1:0] id_dst,
  input  logic [1:0]      id_class,
  input  logic            pipe_freeze,
  output logic            pc_write,
  output logic            ifid_write,
  output logic            ctrl_sel,
  output logic [1:0]      stall_cause,
  output logic [CNTW-1:0] stall_count,
  output logic            sb_busy
);
  localparam int NREG = 2**REGW;
  localparam int CW   = $clog2(MD_LAT+BR_EXTRA+1) < 1 ? 1 : $clog2(MD_LAT+BR_EXTRA+1);
  localparam int MW   = MD_OCC > 1 ? $clog2(MD_OCC) : 1;
  logic [CW-1:0]   cnt_q [NREG];
  logic [CW-1:0]   cnt_d [NREG];
  logic [MW-1:0]   md_cnt_q, md_cnt_d;
  logic [CNTW-1:0] stall_count_q, stall_count_d;
  logic [CW-1:0]   tot_id;
  logic            src_rs, src_rt, raw_ex, raw_br, waw, strc, stall, issue, busy;
  always_comb begin
    tot_id = CW'((id_class == 2'b01 ? LOAD_LAT : id_class == 2'b10 ? MD_LAT : 0) + BR_EXTRA);
    src_rs = id_uses_rs && id_rs != '0;
    src_rt = id_uses_rt && id_rt != '0;
    raw_ex = id_valid && !id_is_branch &&
             ((src_rs && cnt_q[id_rs] > CW'(BR_EXTRA)) || (src_rt && cnt_q[id_rt] > CW'(BR_EXTRA)));
    raw_br = id_valid && id_is_branch &&
             ((src_rs && cnt_q[id_rs] != '0) || (src_rt && cnt_q[id_rt] != '0));
    waw    = id_valid && id_regwrite && id_dst != '0 && cnt_q[id_dst] > tot_id;
    strc   = id_valid && id_class == 2'b10 && md_cnt_q != '0;
    stall  = raw_ex || raw_br || waw || strc;
    issue  = id_valid && !stall && !pipe_freeze;
    busy   = md_cnt_q != '0;
    cnt_d[0] = '0;
    for (int i = 1; i < NREG; i++) begin
      busy = busy || cnt_q[i] != '0;
      cnt_d[i] = pipe_freeze ? cnt_q[i] :
                 (issue && id_regwrite && id_dst == REGW'(i)) ? tot_id :
                 cnt_q[i] - CW'(cnt_q[i] != '0);
    end
    md_cnt_d = pipe_freeze ? md_cnt_q :
               (issue && id_class == 2'b10) ? MW'(MD_OCC-1) :
               md_cnt_q - MW'(md_cnt_q != '0);
    stall_count_d = (stall && !(&stall_count_q)) ? stall_count_q + 1'b1 : stall_count_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) cnt_q[i] <= '0;
      md_cnt_q      <= '0;
      stall_count_q <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) cnt_q[i] <= cnt_d[i];
      md_cnt_q      <= md_cnt_d;
      stall_count_q <= stall_count_d;
    end
  end
  // Freeze stops PC/IFID but never injects a bubble; ID/EX holds on its own.
  assign pc_write    = reset || (!stall && !pipe_freeze);
  assign ifid_write  = pc_write;
  assign ctrl_sel    = reset || !stall;
  assign stall_cause = reset ? 2'b00 : strc ? 2'b11 : raw_br ? 2'b10 : (raw_ex || waw) ? 2'b01 : 2'b00;
  assign stall_count = reset ? '0 : stall_count_q;
  assign sb_busy     = busy;
endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// tb_hazard_scoreboard_unit: directed scoreboard bench for the ID-stage stall controller
module tb_hazard_scoreboard_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        id_valid = 1'b0, id_uses_rs = 1'b0, id_uses_rt = 1'b0, id_is_branch = 1'b0, id_regwrite = 1'b0;
  logic [4:0]  id_rs = '0, id_rt = '0, id_dst = '0;
  logic [1:0]  id_class = '0;
  logic        pipe_freeze = 1'b0;
  logic        pc_write, ifid_write, ctrl_sel, sb_busy;
  logic [1:0]  stall_cause;
  logic [15:0] stall_count;
  typedef struct {
    string       nm;
    logic [21:0] v;
  } exp_t;
  exp_t exp_q[$];
  int   n_chk = 0, n_pass = 0;
  hazard_scoreboard_unit dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_is_branch(id_is_branch),
    .id_regwrite(id_regwrite), .id_dst(id_dst), .id_class(id_class), .pipe_freeze(pipe_freeze),
    .pc_write(pc_write), .ifid_write(ifid_write), .ctrl_sel(ctrl_sel), .stall_cause(stall_cause),
    .stall_count(stall_count), .sb_busy(sb_busy)
  );
  always #5 clk = ~clk;
  // Monitor: packed as {pc_write, ifid_write, ctrl_sel, cause, count, busy}.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [21:0] got;
      e = exp_q.pop_front();
      got = {pc_write, ifid_write, ctrl_sel, stall_cause, stall_count, sb_busy};
      n_chk++;
      if (got === e.v) n_pass++;
      else $display("FAIL %s: got pcw=%b ifw=%b csel=%b cause=%b cnt=%0d busy=%b, want pcw=%b ifw=%b csel=%b cause=%b cnt=%0d busy=%b",
                    e.nm, got[21], got[20], got[19], got[18:17], got[16:1], got[0],
                    e.v[21], e.v[20], e.v[19], e.v[18:17], e.v[16:1], e.v[0]);
    end
  end
  task automatic cyc(input string nm, input logic rst, input logic v, input int rs, input int rt,
                     input logic urs, input logic urt, input logic br, input logic rw, input int dst,
                     input logic [1:0] cls, input logic frz,
                     input logic pw, input logic cs, input logic [1:0] ca, input int sc, input logic bz);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst; id_valid = v; id_rs = 5'(rs); id_rt = 5'(rt); id_uses_rs = urs; id_uses_rt = urt;
    id_is_branch = br; id_regwrite = rw; id_dst = 5'(dst); id_class = cls; pipe_freeze = frz;
    e.nm = nm;
    e.v = {pw, pw, cs, ca, 16'(sc), bz};
    exp_q.push_back(e);
  endtask
  task automatic idle(input string nm, input logic frz, input logic pw, input int sc, input logic bz);
    cyc(nm, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, frz, pw, 1, 2'b00, sc, bz);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    cyc("reset",      1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 1, 2'b00, 0, 0);
    // load-use: one EX stall
    cyc("lw_issue",   0, 1, 0, 0, 1, 0, 0, 1, 2, 2'b01, 0, 1, 1, 2'b00, 0, 0);
    cyc("lu_stall",   0, 1, 2, 4, 1, 1, 0, 1, 3, 2'b00, 0, 0, 0, 2'b01, 0, 1);
    cyc("lu_issue",   0, 1, 2, 4, 1, 1, 0, 1, 3, 2'b00, 0, 1, 1, 2'b00, 1, 1);
    idle("lu_drain1", 0, 1, 1, 1);
    idle("lu_drain2", 0, 1, 1, 0);
    // load then branch: two branch stalls
    cyc("lwb_issue",  0, 1, 0, 0, 1, 0, 0, 1, 2, 2'b01, 0, 1, 1, 2'b00, 1, 0);
    cyc("lwb_st1",    0, 1, 2, 5, 1, 1, 1, 0, 0, 2'b00, 0, 0, 0, 2'b10, 1, 1);
    cyc("lwb_st2",    0, 1, 2, 5, 1, 1, 1, 0, 0, 2'b00, 0, 0, 0, 2'b10, 2, 1);
    cyc("lwb_go",     0, 1, 2, 5, 1, 1, 1, 0, 0, 2'b00, 0, 1, 1, 2'b00, 3, 0);
    // ALU then branch: one stall
    cyc("addi_issue", 0, 1, 1, 0, 1, 0, 0, 1, 2, 2'b00, 0, 1, 1, 2'b00, 3, 0);
    cyc("ab_st1",     0, 1, 2, 5, 1, 1, 1, 0, 0, 2'b00, 0, 0, 0, 2'b10, 3, 1);
    cyc("ab_go",      0, 1, 2, 5, 1, 1, 1, 0, 0, 2'b00, 0, 1, 1, 2'b00, 4, 0);
    // back-to-back mul/div: three structural stalls
    cyc("mul1_issue", 0, 1, 9, 10, 1, 1, 0, 1, 8, 2'b10, 0, 1, 1, 2'b00, 4, 0);
    cyc("mul2_st1",   0, 1, 12, 13, 1, 1, 0, 1, 11, 2'b10, 0, 0, 0, 2'b11, 4, 1);
    cyc("mul2_st2",   0, 1, 12, 13, 1, 1, 0, 1, 11, 2'b10, 0, 0, 0, 2'b11, 5, 1);
    cyc("mul2_st3",   0, 1, 12, 13, 1, 1, 0, 1, 11, 2'b10, 0, 0, 0, 2'b11, 6, 1);
    cyc("mul2_go",    0, 1, 12, 13, 1, 1, 0, 1, 11, 2'b10, 0, 1, 1, 2'b00, 7, 1);
    idle("md_drain1", 0, 1, 7, 1);
    idle("md_drain2", 0, 1, 7, 1);
    idle("md_drain3", 0, 1, 7, 1);
    idle("md_drain4", 0, 1, 7, 1);
    idle("md_empty",  0, 1, 7, 0);
    // mul result consumed by ALU: three RAW stalls
    cyc("mul3_issue", 0, 1, 9, 10, 1, 1, 0, 1, 8, 2'b10, 0, 1, 1, 2'b00, 7, 0);
    cyc("mraw_st1",   0, 1, 8, 0, 1, 1, 0, 1, 9, 2'b00, 0, 0, 0, 2'b01, 7, 1);
    cyc("mraw_st2",   0, 1, 8, 0, 1, 1, 0, 1, 9, 2'b00, 0, 0, 0, 2'b01, 8, 1);
    cyc("mraw_st3",   0, 1, 8, 0, 1, 1, 0, 1, 9, 2'b00, 0, 0, 0, 2'b01, 9, 1);
    cyc("mraw_go",    0, 1, 8, 0, 1, 1, 0, 1, 9, 2'b00, 0, 1, 1, 2'b00, 10, 1);
    idle("mraw_drain", 0, 1, 10, 1);
    // WAW: load to $8 while mul to $8 pending
    cyc("mul4_issue", 0, 1, 9, 10, 1, 1, 0, 1, 8, 2'b10, 0, 1, 1, 2'b00, 10, 0);
    cyc("waw_st1",    0, 1, 0, 0, 1, 0, 0, 1, 8, 2'b01, 0, 0, 0, 2'b01, 10, 1);
    cyc("waw_st2",    0, 1, 0, 0, 1, 0, 0, 1, 8, 2'b01, 0, 0, 0, 2'b01, 11, 1);
    cyc("waw_go",     0, 1, 0, 0, 1, 0, 0, 1, 8, 2'b01, 0, 1, 1, 2'b00, 12, 1);
    idle("waw_drain1", 0, 1, 12, 1);
    idle("waw_drain2", 0, 1, 12, 1);
    idle("waw_empty",  0, 1, 12, 0);
    // freeze holds the scoreboard
    cyc("frz_lw",     0, 1, 0, 0, 1, 0, 0, 1, 2, 2'b01, 0, 1, 1, 2'b00, 12, 0);
    for (int i = 0; i < 5; i++) idle("frz_hold", 1, 0, 12, 1);
    cyc("frz_st1",    0, 1, 2, 4, 1, 1, 0, 1, 3, 2'b00, 0, 0, 0, 2'b01, 12, 1);
    cyc("frz_go",     0, 1, 2, 4, 1, 1, 0, 1, 3, 2'b00, 0, 1, 1, 2'b00, 13, 1);
    idle("frz_drain", 0, 1, 13, 1);
    idle("frz_empty", 0, 1, 13, 0);
    // r0 is never tracked
    cyc("r0_write",   0, 1, 1, 2, 1, 1, 0, 1, 0, 2'b00, 0, 1, 1, 2'b00, 13, 0);
    cyc("r0_branch",  0, 1, 0, 0, 1, 1, 1, 0, 0, 2'b00, 0, 1, 1, 2'b00, 13, 0);
    // reset in the middle of a stall
    cyc("rst_lw",     0, 1, 0, 0, 1, 0, 0, 1, 2, 2'b01, 0, 1, 1, 2'b00, 13, 0);
    cyc("rst_st1",    0, 1, 2, 4, 1, 1, 0, 1, 3, 2'b00, 0, 0, 0, 2'b01, 13, 1);
    cyc("rst_during", 1, 1, 2, 4, 1, 1, 0, 1, 3, 2'b00, 0, 1, 1, 2'b00, 0, 1);
    idle("rst_after", 0, 1, 0, 0);
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_chk++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
